// File: rtl/or8_chk_pkg.sv
// Shared types and constants for the exhaustive 8-input OR checker.
package or8_chk_pkg;

  localparam int unsigned VEC_W     = 8;
  localparam int unsigned N_VECTORS = 256;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned HOLD_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } or8_state_e;

  function automatic logic or8_expected(input logic [VEC_W-1:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/or8_hold_timer.sv
// Down-counter that times how long each stimulus vector is held; tc_o flags zero.
module or8_hold_timer
  import or8_chk_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [HOLD_W-1:0] load_val_i,
  output logic              tc_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/or8_exhaustive_checker.sv
// Walks all 256 input vectors through an external 8-input OR and counts mismatches.
// Define OR8_FIRST_FAIL_CAPTURE_EN to record the first failing vector on fail_vec.
module or8_exhaustive_checker
  import or8_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             O,
  output logic             I0,
  output logic             I1,
  output logic             I2,
  output logic             I3,
  output logic             I4,
  output logic             I5,
  output logic             I6,
  output logic             I7,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  // Counter is loaded with HOLD_CYCLES-1 so HOLD spans exactly HOLD_CYCLES cycles.
  localparam logic [HOLD_W-1:0] HoldLoad = HOLD_W'(HOLD_CYCLES - 1);

  or8_state_e       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             timer_load;
  logic             timer_en;
  logic             hold_tc;
  logic             mismatch;

  or8_hold_timer u_hold_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (timer_load),
    .en_i       (timer_en),
    .load_val_i (HoldLoad),
    .tc_o       (hold_tc)
  );

  assign mismatch = (O != or8_expected(vec_q));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = HOLD;
          vec_d      = '0;
          err_d      = '0;
          timer_load = 1'b1;
        end
      end
      HOLD: begin
        if (hold_tc) begin
          state_d = CHECK;
        end else begin
          timer_en = 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + CNT_W'(1);
        end
        if (vec_q == '1) begin
          state_d = DONE;
        end else begin
          vec_d      = vec_q + VEC_W'(1);
          state_d    = HOLD;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

`ifdef OR8_FIRST_FAIL_CAPTURE_EN
  logic             first_q, first_d;
  logic [VEC_W-1:0] fail_q, fail_d;
  logic             cap_start;

  assign cap_start = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    first_d = first_q;
    fail_d  = fail_q;
    if (cap_start) begin
      first_d = 1'b0;
      fail_d  = '0;
    end else if ((state_q == CHECK) && mismatch && !first_q) begin
      first_d = 1'b1;
      fail_d  = vec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      first_q <= first_d;
      fail_q  <= fail_d;
    end
  end

  assign fail_vec = fail_q;
`else
  assign fail_vec = '0;
`endif

  assign busy      = (state_q == HOLD) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

  // I0 carries the vector MSB.
  assign {I0, I1, I2, I3, I4, I5, I6, I7} = busy ? vec_q : '0;

endmodule

// File: tb/tb_or8_exhaustive_checker.sv
// Scoreboard bench: two checker instances (HOLD_CYCLES 4 and 1) against a faultable OR model.
module tb_or8_exhaustive_checker;

  localparam int H4 = 4;
  localparam int H1 = 1;
`ifdef OR8_FIRST_FAIL_CAPTURE_EN
  localparam logic [7:0] FvStuck0 = 8'h01;
  localparam logic [7:0] FvAbort  = 8'h01;
`else
  localparam logic [7:0] FvStuck0 = 8'h00;
  localparam logic [7:0] FvAbort  = 8'h00;
`endif

  typedef struct {
    int         err;
    logic       pass;
    logic [7:0] fv;
    int         len;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start4, start1;
  int   fault4;
  wire  [7:0] i4, i1;
  wire  busy4, done4, pass4, busy1, done1, pass1;
  wire  [8:0] err4, err1;
  wire  [7:0] fv4, fv1;
  wire  o4, o1;

  assign o4 = (fault4 == 1) ? 1'b1 : (fault4 == 2) ? 1'b0 : |i4;
  assign o1 = |i1;

  or8_exhaustive_checker #(.HOLD_CYCLES(H4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .O(o4),
    .I0(i4[7]), .I1(i4[6]), .I2(i4[5]), .I3(i4[4]),
    .I4(i4[3]), .I5(i4[2]), .I6(i4[1]), .I7(i4[0]),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_vec(fv4)
  );

  or8_exhaustive_checker #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .O(o1),
    .I0(i1[7]), .I1(i1[6]), .I2(i1[5]), .I3(i1[4]),
    .I4(i1[3]), .I5(i1[2]), .I6(i1[1]), .I7(i1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  res_t sb4[$];
  res_t sb1[$];

  bit         prev_busy[2], prev_done[2], started[2], seq_ok[2];
  logic [7:0] cur_vec[2];
  int         run_len[2], t0[2];
  bit         idle_ok = 1'b1;
  bit         excl_ok = 1'b1;

  function automatic res_t mk(input int err, input logic pass, input logic [7:0] fv,
                              input int len);
    res_t r;
    r.err  = err;
    r.pass = pass;
    r.fv   = fv;
    r.len  = len;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Tracks the vector walk of one instance and scores a result when done rises.
  task automatic mon(input int id, input int h, input logic busy, input logic done,
                     input logic pass, input logic [8:0] err, input logic [7:0] fv,
                     input logic [7:0] ivec);
    res_t e;
    bit   have;
    if (busy && done) excl_ok = 1'b0;
    if (!busy && (ivec != 8'h00)) idle_ok = 1'b0;
    if (busy) begin
      if (!prev_busy[id]) begin
        started[id] = 1'b1;
        t0[id]      = cyc;
        cur_vec[id] = 8'h00;
        run_len[id] = 1;
        seq_ok[id]  = (ivec == 8'h00);
      end else if (ivec == cur_vec[id]) begin
        run_len[id]++;
      end else if ((ivec == cur_vec[id] + 8'd1) && (run_len[id] == h + 1)) begin
        cur_vec[id] = ivec;
        run_len[id] = 1;
      end else begin
        seq_ok[id] = 1'b0;
      end
    end
    if (done && !prev_done[id]) begin
      have = (id == 0) ? (sb4.size() > 0) : (sb1.size() > 0);
      if (!have || !started[id]) begin
        total++;
        bad++;
        $display("FAIL unexpected_done[%0d]: done rose with no run expected", id);
      end else begin
        e = (id == 0) ? sb4.pop_front() : sb1.pop_front();
        chk($sformatf("run_len[%0d]", id), cyc - t0[id], e.len);
        chk($sformatf("err_count[%0d]", id), err, e.err);
        chk($sformatf("pass[%0d]", id), pass, e.pass);
        chk($sformatf("fail_vec[%0d]", id), fv, e.fv);
        chk($sformatf("vector_walk[%0d]", id),
            seq_ok[id] && (cur_vec[id] == 8'hFF) && (run_len[id] == h + 1), 1);
      end
      started[id] = 1'b0;
    end
    prev_busy[id] = busy;
    prev_done[id] = done;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, H4, busy4, done4, pass4, err4, fv4, i4);
    mon(1, H1, busy1, done1, pass1, err1, fv1, i1);
  end

  task automatic wait_done4(input int bound, input string name);
    int n = 0;
    while (!done4 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done4) begin
      total++;
      bad++;
      $display("FAIL %s: done still 0 after %0d cycles, expected 1", name, bound);
    end
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    fault4 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_pass", pass4, 0);
    chk("rst_err", err4, 0);
    chk("rst_fv", fv4, 0);
    chk("rst_ivec", i4, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run on both instances; a stray start mid-run must be ignored.
    sb4.push_back(mk(0, 1'b1, 8'h00, 256 * (H4 + 1)));
    sb1.push_back(mk(0, 1'b1, 8'h00, 256 * (H1 + 1)));
    start4 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start1 = 1'b0;
    repeat (100) @(negedge clk);
    pulse_start4();
    wait_done4(1400, "run_clean");
    repeat (6) @(negedge clk);
    chk("done_held", done4, 1);
    chk("pass_held", pass4, 1);
    chk("err_held", err4, 0);
    chk("done_ivec_zero", i4, 0);

    // Stuck-at-1: only vector 0 mismatches.
    fault4 = 1;
    sb4.push_back(mk(1, 1'b0, 8'h00, 256 * (H4 + 1)));
    pulse_start4();
    wait_done4(1400, "run_stuck1");

    // Stuck-at-0: every nonzero vector mismatches.
    fault4 = 2;
    sb4.push_back(mk(255, 1'b0, FvStuck0, 256 * (H4 + 1)));
    pulse_start4();
    wait_done4(1400, "run_stuck0");

    // Abort with reset at vector 8'h37 while errors are accumulating.
    pulse_start4();
    n = 0;
    while ((i4 != 8'h37) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_37", i4, 8'h37);
    chk("abort_err_before", err4, 8'h36);
    chk("abort_fv_before", fv4, FvAbort);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_pass", pass4, 0);
    chk("abort_err", err4, 0);
    chk("abort_fv", fv4, 0);
    chk("abort_ivec", i4, 0);
    fault4 = 0;
    sb4.push_back(mk(0, 1'b1, 8'h00, 256 * (H4 + 1)));
    pulse_start4();
    wait_done4(1400, "run_after_abort");

    // Start held high across a whole run: one DONE cycle then an immediate restart.
    sb4.push_back(mk(0, 1'b1, 8'h00, 256 * (H4 + 1)));
    sb4.push_back(mk(0, 1'b1, 8'h00, 256 * (H4 + 1)));
    start4 = 1'b1;
    @(negedge clk);
    wait_done4(1400, "run_held_1");
    @(negedge clk);
    chk("held_done_one_cycle", done4, 0);
    chk("held_restart_busy", busy4, 1);
    chk("held_restart_vec", i4, 0);
    start4 = 1'b0;
    wait_done4(1400, "run_held_2");

    repeat (3) @(negedge clk);
    chk("sb4_drained", sb4.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    chk("idle_ivec_zero", idle_ok, 1);
    chk("busy_done_exclusive", excl_ok, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
